// File: rtl/mod_mul_digit.sv
// mod_mul_digit
//   Multi-mode modular arithmetic unit for the elliptic-curve datapath.
//   Computes a*b mod P, a^2 mod P, (a+b) mod P or (a-b) mod P.
//   Multiplication is digit-serial with interleaved reduction: DIGIT bits of
//   the multiplier are consumed per cycle, MSB digit first, so a multiply
//   takes NDIG = ceil(WIDTH/DIGIT) RUN cycles. ADD/SUB finish in the
//   acceptance cycle.
//
// Parameters
//   WIDTH  operand/result width
//   P      modulus, odd, 2 < P < 2^WIDTH
//   DIGIT  multiplier bits per iteration, 1..8
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operation presented
//   in_ready   block accepts an operation (IDLE only)
//   op         00 MUL, 01 SQR, 10 ADD, 11 SUB (a-b)
//   a, b       operands, expected < P
//   out_valid  r holds a result
//   out_ready  consumer takes r
//   r          result in [0, P)
module mod_mul_digit #(
    parameter int               WIDTH = 377,
    parameter logic [WIDTH-1:0] P     = 377'h1_ae3a4617_c510eac6_3b05c06c_a1493b1a_22d9f300_f5138f1e_f3622fba_09480017_0b5d4430_00000085_08c00000_000001,
    parameter int               DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r
);

    localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int BW   = NDIG * DIGIT;
    localparam int TW   = WIDTH + DIGIT + 1;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_SQR = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // (x + y) mod P; the sum needs one extra bit before the single correction.
    function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, P})
            s = s - {1'b0, P};
        return WIDTH'(s);
    endfunction

    // (x - y) mod P; on borrow the wrapped difference plus P lands in range.
    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        if (x >= y)
            return x - y;
        else
            return x - y + P;
    endfunction

    // One interleaved step: t = acc*2^DIGIT + d*x, then reduce.
    // t < (2^(DIGIT+1)-1)*P, so conditionally subtracting P*2^j for
    // j = DIGIT..0 leaves t < P. TW bits hold t without overflow.
    function automatic logic [WIDTH-1:0] mul_step(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [DIGIT-1:0] d);
        logic [TW-1:0] t;
        t = TW'(acc) << DIGIT;
        for (int i = 0; i < DIGIT; i++) begin
            if (d[i])
                t = t + (TW'(x) << i);
        end
        for (int j = DIGIT; j >= 0; j--) begin
            if (t >= (TW'(P) << j))
                t = t - (TW'(P) << j);
        end
        return WIDTH'(t);
    endfunction

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [BW-1:0]    r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT-1:0] w_digit;
    logic [WIDTH-1:0] w_mul_next;
    logic [WIDTH-1:0] w_addsub;
    logic             w_last;

    // Multiplier is shifted left each cycle so the current digit is always on top.
    assign w_digit    = r_b[BW-1 -: DIGIT];
    assign w_mul_next = mul_step(r_acc, r_a, w_digit);
    assign w_addsub   = op[0] ? sub_mod(a, b) : add_mod(a, b);
    assign w_last     = (r_cnt == CW'(NDIG - 1));

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_HOLD);
    assign r         = r_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        case (op)
                            OP_MUL, OP_SQR: begin
                                r_a     <= a;
                                // Squaring reuses the multiply path with b <- a.
                                r_b     <= (op == OP_SQR) ? BW'(a) : BW'(b);
                                r_acc   <= '0;
                                r_cnt   <= '0;
                                r_state <= S_RUN;
                            end
                            OP_ADD, OP_SUB: begin
                                r_acc   <= w_addsub;
                                r_state <= S_HOLD;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_RUN: begin
                    r_acc <= w_mul_next;
                    r_b   <= r_b << DIGIT;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul_digit.sv
module tb_mod_mul_digit;

    localparam logic [376:0] P_BIG = 377'h1_ae3a4617_c510eac6_3b05c06c_a1493b1a_22d9f300_f5138f1e_f3622fba_09480017_0b5d4430_00000085_08c00000_000001;
    localparam logic [376:0] A_BIG = 377'h1_647170e8_c3f25a9d_04b71e63_5a8c2f09_17be4d36_c05a81f2_e9d4b73c_81a06f59_e2d73b40_8c6f1a53_d92e7b04_f1eb11;
    localparam logic [376:0] B_BIG = 377'h1_44b54783_9a0c6e2d_71f5b308_c4e9a16d_2b7f0358_e6a91c4d_0f83b27e_5c1d9a64_b3e70f28_a95c41d6_07e3b8f2_c1f416;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // WIDTH=8, P=251, DIGIT=2
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [1:0] s_op;
    logic [7:0] s_a, s_b, s_r;

    // default parameters
    logic         g_in_valid, g_in_ready, g_out_valid, g_out_ready;
    logic [1:0]   g_op;
    logic [376:0] g_a, g_b, g_r;

    // WIDTH=13, P=8191, DIGIT in {1,3,8}, shared inputs
    logic        c_in_valid, c_out_ready;
    logic [1:0]  c_op;
    logic [12:0] c_a, c_b;
    logic        c1_in_ready, c1_out_valid, c3_in_ready, c3_out_valid, c8_in_ready, c8_out_valid;
    logic [12:0] c1_r, c3_r, c8_r;

    mod_mul_digit #(.WIDTH(8), .P(8'd251), .DIGIT(2)) u_small (
        .clk(clk), .reset_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op(s_op), .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .r(s_r));

    mod_mul_digit u_big (
        .clk(clk), .reset_n(rst_n), .in_valid(g_in_valid), .in_ready(g_in_ready),
        .op(g_op), .a(g_a), .b(g_b), .out_valid(g_out_valid), .out_ready(g_out_ready), .r(g_r));

    mod_mul_digit #(.WIDTH(13), .P(13'd8191), .DIGIT(1)) u_d1 (
        .clk(clk), .reset_n(rst_n), .in_valid(c_in_valid), .in_ready(c1_in_ready),
        .op(c_op), .a(c_a), .b(c_b), .out_valid(c1_out_valid), .out_ready(c_out_ready), .r(c1_r));

    mod_mul_digit #(.WIDTH(13), .P(13'd8191), .DIGIT(3)) u_d3 (
        .clk(clk), .reset_n(rst_n), .in_valid(c_in_valid), .in_ready(c3_in_ready),
        .op(c_op), .a(c_a), .b(c_b), .out_valid(c3_out_valid), .out_ready(c_out_ready), .r(c3_r));

    mod_mul_digit #(.WIDTH(13), .P(13'd8191), .DIGIT(8)) u_d8 (
        .clk(clk), .reset_n(rst_n), .in_valid(c_in_valid), .in_ready(c8_in_ready),
        .op(c_op), .a(c_a), .b(c_b), .out_valid(c8_out_valid), .out_ready(c_out_ready), .r(c8_r));

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op on the small instance; returns result and latency in cycles
    // (1 = valid right after the acceptance edge).
    task automatic run_small(input logic [1:0] op, input logic [7:0] xa, input logic [7:0] xb,
                             output logic [7:0] res, output int lat);
        @(negedge clk);
        s_op = op; s_a = xa; s_b = xb; s_in_valid = 1'b1; s_out_ready = 1'b0;
        @(negedge clk);
        s_in_valid = 1'b0; s_a = ~xa; s_b = ~xb;
        lat = 1;
        while (!s_out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = s_r;
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
    endtask

    task automatic run_big(input logic [1:0] op, input logic [376:0] xa, input logic [376:0] xb,
                           output logic [376:0] res, output int lat);
        @(negedge clk);
        g_op = op; g_a = xa; g_b = xb; g_in_valid = 1'b1; g_out_ready = 1'b0;
        @(negedge clk);
        g_in_valid = 1'b0; g_a = ~xa; g_b = ~xb;
        lat = 1;
        while (!g_out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        res = g_r;
        g_out_ready = 1'b1;
        @(negedge clk);
        g_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_in_valid = 0; s_op = 0; s_a = 0; s_b = 0; s_out_ready = 0;
        g_in_valid = 0; g_op = 0; g_a = 0; g_b = 0; g_out_ready = 0;
        c_in_valid = 0; c_op = 0; c_a = 0; c_b = 0; c_out_ready = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({s_in_ready, s_out_valid} !== 2'b10 || s_r !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_small: in_ready=%b out_valid=%b r=%0d, want 1 0 0", s_in_ready, s_out_valid, s_r);
        end
        n_checks++;
        if ({g_in_ready, g_out_valid} !== 2'b10 || g_r !== '0) begin
            n_fail++;
            $display("FAIL reset_big: in_ready=%b out_valid=%b r=%h, want 1 0 0", g_in_ready, g_out_valid, g_r);
        end
        n_checks++;
        if ({c1_in_ready, c3_in_ready, c8_in_ready, c1_out_valid, c3_out_valid, c8_out_valid} !== 6'b111000
            || c1_r !== 13'd0 || c3_r !== 13'd0 || c8_r !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_w13: rdy=%b%b%b vld=%b%b%b r=%0d/%0d/%0d, want 111 000 0",
                     c1_in_ready, c3_in_ready, c8_in_ready, c1_out_valid, c3_out_valid, c8_out_valid, c1_r, c3_r, c8_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_small_ops();
        logic [1:0] vop [9];
        logic [7:0] va [9];
        logic [7:0] vb [9];
        logic [7:0] vr [9];
        int         vl [9];
        logic [7:0] res;
        int         lat;
        vop = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
        va  = '{8'd200, 8'd250, 8'd200, 8'd150, 8'd7, 8'd250, 8'd250, 8'd0, 8'd3};
        vb  = '{8'd150, 8'd0, 8'd150, 8'd200, 8'd7, 8'd1, 8'd250, 8'd123, 8'd5};
        vr  = '{8'd131, 8'd1, 8'd99, 8'd201, 8'd0, 8'd0, 8'd1, 8'd0, 8'd15};
        vl  = '{5, 5, 1, 1, 1, 1, 5, 5, 5};
        for (int i = 0; i < 9; i++) begin
            run_small(vop[i], va[i], vb[i], res, lat);
            n_checks++;
            if (res !== vr[i]) begin
                n_fail++;
                $display("FAIL small_r[%0d] op=%0d a=%0d b=%0d: got %0d, want %0d", i, vop[i], va[i], vb[i], res, vr[i]);
            end
            n_checks++;
            if (lat !== vl[i]) begin
                n_fail++;
                $display("FAIL small_latency[%0d]: got %0d, want %0d", i, lat, vl[i]);
            end
            n_checks++;
            if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL small_return_idle[%0d]: in_ready=%b out_valid=%b, want 1 0", i, s_in_ready, s_out_valid);
            end
        end
    endtask

    task automatic test_big_mul();
        logic [376:0] xa [2];
        logic [376:0] xb [2];
        logic [753:0] prod;
        logic [376:0] expv, res;
        int           lat;
        xa[0] = A_BIG;         xb[0] = B_BIG;
        xa[1] = P_BIG - 1'b1;  xb[1] = P_BIG - 1'b1;
        for (int i = 0; i < 2; i++) begin
            prod = {377'b0, xa[i]} * {377'b0, xb[i]};
            prod = prod % {377'b0, P_BIG};
            expv = prod[376:0];
            run_big(2'b00, xa[i], xb[i], res, lat);
            n_checks++;
            if (res !== expv) begin
                n_fail++;
                $display("FAIL big_mul_r[%0d]: got %h, want %h", i, res, expv);
            end
            n_checks++;
            if (lat !== 96) begin
                n_fail++;
                $display("FAIL big_mul_latency[%0d]: got %0d, want 96", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        @(negedge clk);
        s_op = 2'b00; s_a = 8'd200; s_b = 8'd150; s_in_valid = 1'b1; s_out_ready = 1'b0;
        @(negedge clk);
        s_in_valid = 1'b0;
        cyc = 0;
        while (!s_out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 || s_r !== 8'd131) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b r=%0d, want 1 0 131",
                         c, s_out_valid, s_in_ready, s_r);
            end
            if (c == 4) begin
                s_op = 2'b10; s_a = 8'd1; s_b = 8'd1; s_in_valid = 1'b1;
            end
            if (c == 5)
                s_in_valid = 1'b0;
            @(negedge clk);
        end
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        n_checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0", s_in_ready, s_out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_ignored_pulse: in_ready=%b out_valid=%b, want 1 0", s_in_ready, s_out_valid);
        end
    endtask

    task automatic test_reset_abort();
        logic [376:0] res;
        int           lat;
        @(negedge clk);
        g_op = 2'b00; g_a = A_BIG; g_b = B_BIG; g_in_valid = 1'b1; g_out_ready = 1'b0;
        @(negedge clk);
        g_in_valid = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (g_out_valid !== 1'b0 || g_r !== '0 || g_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_abort: out_valid=%b in_ready=%b r=%h, want 0 1 0", g_out_valid, g_in_ready, g_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_big(2'b00, 377'd3, 377'd5, res, lat);
        n_checks++;
        if (res !== 377'd15) begin
            n_fail++;
            $display("FAIL reset_after_mul: got %h, want 15", res);
        end
        n_checks++;
        if (lat !== 96) begin
            n_fail++;
            $display("FAIL reset_after_latency: got %0d, want 96", lat);
        end
    endtask

    task automatic test_sweep();
        logic [12:0] xa, xb, er;
        logic [2:0]  seen;
        logic [2:0]  vld;
        logic [12:0] rr  [3];
        logic [12:0] got [3];
        int          lat [3];
        int          el  [3];
        int          cyc;
        c_out_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            for (int o = 0; o < 4; o++) begin
                xa = 13'($urandom_range(0, 8190));
                xb = 13'($urandom_range(0, 8190));
                case (o)
                    0:       er = 13'((int'(xa) * int'(xb)) % 8191);
                    1:       er = 13'((int'(xa) * int'(xa)) % 8191);
                    2:       er = 13'((int'(xa) + int'(xb)) % 8191);
                    default: er = 13'((int'(xa) + 8191 - int'(xb)) % 8191);
                endcase
                if (o < 2) begin
                    el[0] = 14; el[1] = 6; el[2] = 3;
                end else begin
                    el[0] = 1; el[1] = 1; el[2] = 1;
                end
                cyc = 0;
                while (!(c1_in_ready && c3_in_ready && c8_in_ready) && cyc < 10) begin
                    @(negedge clk);
                    cyc++;
                end
                c_op = 2'(o); c_a = xa; c_b = xb; c_in_valid = 1'b1;
                @(negedge clk);
                c_in_valid = 1'b0; c_a = ~xa; c_b = ~xb;
                seen = 3'b000;
                lat[0] = 0; lat[1] = 0; lat[2] = 0;
                got[0] = '0; got[1] = '0; got[2] = '0;
                cyc = 1;
                while (seen != 3'b111 && cyc <= 40) begin
                    vld = {c8_out_valid, c3_out_valid, c1_out_valid};
                    rr[0] = c1_r; rr[1] = c3_r; rr[2] = c8_r;
                    for (int d = 0; d < 3; d++) begin
                        if (vld[d] && !seen[d]) begin
                            seen[d] = 1'b1;
                            lat[d]  = cyc;
                            got[d]  = rr[d];
                        end
                    end
                    if (seen != 3'b111) begin
                        @(negedge clk);
                        cyc++;
                    end
                end
                for (int d = 0; d < 3; d++) begin
                    n_checks++;
                    if (got[d] !== er) begin
                        n_fail++;
                        $display("FAIL sweep_r dut=%0d op=%0d a=%0d b=%0d: got %0d, want %0d", d, o, xa, xb, got[d], er);
                    end
                    n_checks++;
                    if (lat[d] !== el[d]) begin
                        n_fail++;
                        $display("FAIL sweep_latency dut=%0d op=%0d: got %0d, want %0d", d, o, lat[d], el[d]);
                    end
                end
            end
        end
        @(negedge clk);
        c_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_small_ops();
        test_backpressure();
        test_big_mul();
        test_reset_abort();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
